fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the program-counter register. Drives the PC register's next-address and enable inputs, issues addresses to the synchronous instruction memory (1-cycle read latency), and buffers returned instructions with their PCs in a 2-entry queue. Decode consumes the queue through a valid/ready handshake. Taken branches and jumps from execute flush the unit.

---
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : PC sequencing, 1-cycle imem issue, 2-entry {insn,pc} queue
// Revision   : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter int ADDR_W = 12,
  parameter int INSN_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_current,
  output logic [ADDR_W-1:0] pc_next,
  output logic              pc_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INSN_W-1:0] imem_q,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INSN_W-1:0] out_insn,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_plus1
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [INSN_W-1:0] insn_mem [2];
  logic [ADDR_W-1:0] pc_mem   [2];
  logic              head;
  logic              tail;
  logic [1:0]        count;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;

  logic              flush;
  logic              pop;
  logic              push;
  logic              issue;
  logic [1:0]        occupancy;

  assign flush     = redirect_valid & ~reset;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign push      = inflight & ~redirect_valid & ~reset;
  assign occupancy = count + {1'b0, inflight};

  // Credit check: slots taken by the queue plus the pending return, net of
  // this cycle's pop, must leave room for one more return.
  assign issue = ~reset & ~redirect_valid &
                 ({1'b0, occupancy} < (3'd2 + {2'b00, pop}));

  assign pc_next   = flush ? redirect_target : (pc_current + ADDR_ONE);
  assign pc_en     = ~reset & (issue | redirect_valid);
  assign imem_addr = pc_current;

  assign out_insn     = insn_mem[head];
  assign out_pc       = pc_mem[head];
  assign out_pc_plus1 = pc_mem[head] + ADDR_ONE;

  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= 2'd0;
      inflight <= 1'b0;
      head     <= 1'b0;
      tail     <= 1'b0;
    end else begin
      inflight <= issue;
      if (flush) begin
        count <= 2'd0;
        head  <= 1'b0;
        tail  <= 1'b0;
      end else begin
        if (push) tail <= ~tail;
        if (pop)  head <= ~head;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  // Payload storage needs no reset; validity is tracked by count/inflight.
  always_ff @(posedge clock) begin
    if (issue) inflight_pc <= pc_current;
    if (push) begin
      insn_mem[tail] <= imem_q;
      pc_mem[tail]   <= inflight_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : table vectors, directed corner sequences, scoreboard stream
// Revision      : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] pc_current;
  logic [11:0] pc_next;
  logic        pc_en;
  logic [11:0] imem_addr;
  logic [31:0] imem_q;
  logic        redirect_valid;
  logic [11:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic [11:0] out_pc;
  logic [11:0] out_pc_plus1;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.ADDR_W(12), .INSN_W(32)) dut (
    .clock(clock), .reset(reset), .pc_current(pc_current), .pc_next(pc_next),
    .pc_en(pc_en), .imem_addr(imem_addr), .imem_q(imem_q),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn),
    .out_pc(out_pc), .out_pc_plus1(out_pc_plus1)
  );

  always #5 clock = ~clock;

  // PC register and synchronous memory holding i at address i.
  always @(posedge clock) begin
    if (reset)      pc_current <= 12'h000;
    else if (pc_en) pc_current <= pc_next;
    imem_q <= {20'h0, imem_addr};
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Scoreboard of PCs decode should receive, in order.
  logic [11:0] exp_q[$];
  logic        stall = 1'b0;
  logic [11:0] held_pc;
  logic [31:0] held_insn;

  task automatic reload(input logic [11:0] base);
    exp_q.delete();
    for (int k = 0; k < 512; k++) exp_q.push_back(base + 12'(k));
  endtask

  always @(negedge clock) begin
    logic [11:0] e;
    logic [11:0] e1;
    if (reset) begin
      reload(12'h000);
    end else begin
      if (stall) begin
        chk("hold_valid", {31'b0, out_valid}, 32'd1);
        chk("hold_pc", {20'b0, out_pc}, {20'b0, held_pc});
        chk("hold_insn", out_insn, held_insn);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got pc %h expected no output", out_pc);
        end else begin
          e  = exp_q.pop_front();
          e1 = e + 12'd1;
          chk("sb_pc", {20'b0, out_pc}, {20'b0, e});
          chk("sb_insn", out_insn, {20'b0, e});
          chk("sb_plus1", {20'b0, out_pc_plus1}, {20'b0, e1});
        end
      end
      if (redirect_valid) reload(redirect_target);
    end
    stall     = !reset && out_valid && !out_ready && !redirect_valid;
    held_pc   = out_pc;
    held_insn = out_insn;
  end

  typedef struct {
    logic        ready;
    logic        redir;
    logic [11:0] target;
    logic        exp_valid;
    logic [11:0] exp_pc;
    logic        exp_pc_en;
    logic [11:0] exp_pc_next;
  } vec_t;

  vec_t tbl[23];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic redirect_seq(input logic [11:0] target, input logic ready_val);
    redirect_valid  = 1'b1;
    redirect_target = target;
    out_ready       = ready_val;
    @(negedge clock);
    chk("redir_pc_next", {20'b0, pc_next}, {20'b0, target});
    chk("redir_pc_en", {31'b0, pc_en}, 32'd1);
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      chk("redir_gap_valid", {31'b0, out_valid}, 32'd0);
      step();
    end
    @(negedge clock);
    chk("redir_first_valid", {31'b0, out_valid}, 32'd1);
    chk("redir_first_pc", {20'b0, out_pc}, {20'b0, target});
    step();
  endtask

  initial begin
    logic        found;
    logic [11:0] exp_next;

    // Cycle-by-cycle expectations from reset release (c0) onward.
    tbl[0]  = '{1'b1, 1'b0, 12'h0, 1'b0, 12'h000, 1'b1, 12'h001};
    tbl[1]  = '{1'b1, 1'b0, 12'h0, 1'b0, 12'h000, 1'b1, 12'h002};
    tbl[2]  = '{1'b1, 1'b0, 12'h0, 1'b1, 12'h000, 1'b1, 12'h003};
    tbl[3]  = '{1'b1, 1'b0, 12'h0, 1'b1, 12'h001, 1'b1, 12'h004};
    for (int k = 4; k < 14; k++)
      tbl[k] = '{1'b0, 1'b0, 12'h0, 1'b1, 12'h002, 1'b0, 12'h005};
    tbl[14] = '{1'b1, 1'b0, 12'h0, 1'b1, 12'h002, 1'b1, 12'h005};
    tbl[15] = '{1'b1, 1'b0, 12'h0, 1'b1, 12'h003, 1'b1, 12'h006};
    tbl[16] = '{1'b1, 1'b0, 12'h0, 1'b1, 12'h004, 1'b1, 12'h007};
    tbl[17] = '{1'b0, 1'b0, 12'h0, 1'b1, 12'h005, 1'b0, 12'h008};
    tbl[18] = '{1'b0, 1'b1, 12'h100, 1'b1, 12'h005, 1'b1, 12'h100};
    tbl[19] = '{1'b1, 1'b0, 12'h0, 1'b0, 12'h000, 1'b1, 12'h101};
    tbl[20] = '{1'b1, 1'b0, 12'h0, 1'b0, 12'h000, 1'b1, 12'h102};
    tbl[21] = '{1'b1, 1'b0, 12'h0, 1'b1, 12'h100, 1'b1, 12'h103};
    tbl[22] = '{1'b1, 1'b0, 12'h0, 1'b1, 12'h101, 1'b1, 12'h104};

    reset           = 1'b1;
    out_ready       = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 12'h000;
    repeat (3) step();
    @(negedge clock);
    chk("reset_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_pc_en", {31'b0, pc_en}, 32'd0);
    chk("reset_pc_next", {20'b0, pc_next}, 32'd1);
    step();
    reset = 1'b0;

    for (int i = 0; i < 23; i++) begin
      out_ready       = tbl[i].ready;
      redirect_valid  = tbl[i].redir;
      redirect_target = tbl[i].target;
      @(negedge clock);
      chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].exp_valid});
      if (tbl[i].exp_valid)
        chk($sformatf("vec%0d_pc", i), {20'b0, out_pc}, {20'b0, tbl[i].exp_pc});
      chk($sformatf("vec%0d_pc_en", i), {31'b0, pc_en}, {31'b0, tbl[i].exp_pc_en});
      chk($sformatf("vec%0d_pc_next", i), {20'b0, pc_next}, {20'b0, tbl[i].exp_pc_next});
      step();
    end
    redirect_valid = 1'b0;
    out_ready      = 1'b1;

    // Redirect coinciding with a pop while streaming.
    repeat (3) step();
    redirect_seq(12'h200, 1'b1);
    repeat (3) step();

    // Redirect while decode is stalled.
    out_ready = 1'b0;
    repeat (4) step();
    redirect_seq(12'h300, 1'b0);
    repeat (2) step();

    // Address wrap at the top of the space.
    redirect_seq(12'hFFE, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clock);
      if (out_valid && out_pc == 12'hFFF) begin
        found = 1'b1;
        chk("wrap_plus1", {20'b0, out_pc_plus1}, 32'h000);
      end
      step();
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wrap_timeout: got no pc fff expected pc fff within 10 cycles");
    end
    repeat (3) step();

    // Reset mid-stream with entries queued; a concurrent redirect is ignored.
    out_ready = 1'b0;
    repeat (2) step();
    reset           = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 12'h333;
    out_ready       = 1'b1;
    @(negedge clock);
    exp_next = pc_current + 12'd1;
    chk("rst_mid_pc_en", {31'b0, pc_en}, 32'd0);
    chk("rst_mid_pc_next", {20'b0, pc_next}, {20'b0, exp_next});
    step();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clock);
    chk("rst_mid_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_mid_issue", {31'b0, pc_en}, 32'd1);
    chk("rst_mid_pc_next0", {20'b0, pc_next}, 32'd1);
    step();
    @(negedge clock);
    chk("rst_mid_gap", {31'b0, out_valid}, 32'd0);
    step();
    @(negedge clock);
    chk("rst_mid_first_valid", {31'b0, out_valid}, 32'd1);
    chk("rst_mid_first_pc", {20'b0, out_pc}, 32'd0);
    step();

    // Random backpressure and redirects, checked by the scoreboard.
    for (int k = 0; k < 300; k++) begin
      out_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid  = ($urandom_range(0, 15) == 0);
      redirect_target = 12'($urandom());
      step();
    end
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
